// File: rtl/rmt_ingress_classifier_if.sv
// ---------------------------------------------------------------------------
// rmt_ingress_classifier_if
// AXI4-Stream bundle used on every stream port of the ingress classifier.
//   tdata  DATA_W      payload, byte n = tdata[8n+7:8n]
//   tkeep  DATA_W/8    byte enables
//   tuser  USER_W      sideband, carried through untouched
//   tvalid 1           beat valid (master -> slave)
//   tlast  1           last beat of packet
//   tready 1           beat accepted (slave -> master)
// modport master: drives the beat, samples tready.
// modport slave : samples the beat, drives tready.
// ---------------------------------------------------------------------------
interface rmt_ingress_classifier_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/rmt_ingress_classifier.sv
// ---------------------------------------------------------------------------
// rmt_ingress_classifier
// Looks at the first beat of every AXIS packet and steers the whole packet
// to the data port (RMT pipeline), the control port (table reconfiguration)
// or drops it. Each output port has a one-entry registered buffer with full
// backpressure; per-class packet counters are exposed for debug.
// Ports:
//   clk           stream clock
//   aresetn       active-low reset, asserts asynchronously; deassertion is
//                 expected to be synchronous to clk (upstream reset bridge)
//   s_axis        input stream (slave)
//   m_data_axis   data output stream (master)
//   m_ctrl_axis   control output stream (master)
//   data_pkt_cnt  packets fully sent on m_data_axis
//   ctrl_pkt_cnt  packets fully sent on m_ctrl_axis
//   drop_pkt_cnt  packets dropped
// ---------------------------------------------------------------------------
module rmt_ingress_classifier #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2,
  parameter int          CNT_WIDTH            = 32
) (
  input  logic                     clk,
  input  logic                     aresetn,
  rmt_ingress_classifier_if.slave  s_axis,
  rmt_ingress_classifier_if.master m_data_axis,
  rmt_ingress_classifier_if.master m_ctrl_axis,
  output logic [CNT_WIDTH-1:0]     data_pkt_cnt,
  output logic [CNT_WIDTH-1:0]     ctrl_pkt_cnt,
  output logic [CNT_WIDTH-1:0]     drop_pkt_cnt
);
  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD_DATA, ST_FWD_CTRL, ST_DROP} state_t;
  typedef enum logic [1:0] {CLS_DROP, CLS_DATA, CLS_CTRL} cls_t;

  state_t state_q;

  logic                            d_valid_q, d_last_q;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  d_data_q;
  logic [KEEP_W-1:0]               d_keep_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] d_user_q;
  logic                            c_valid_q, c_last_q;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  c_data_q;
  logic [KEEP_W-1:0]               c_keep_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] c_user_q;
  logic [CNT_WIDTH-1:0]            data_cnt_q, ctrl_cnt_q, drop_cnt_q;

  // Header fields, big-endian on the wire (lower byte index = MSB).
  logic [15:0] tpid, etype, dport;
  logic [7:0]  proto;
  logic        hdr_valid;
  cls_t        cls_d;

  assign tpid  = {s_axis.tdata[8*12 +: 8], s_axis.tdata[8*13 +: 8]};
  assign etype = {s_axis.tdata[8*16 +: 8], s_axis.tdata[8*17 +: 8]};
  assign proto = s_axis.tdata[8*27 +: 8];
  assign dport = {s_axis.tdata[8*40 +: 8], s_axis.tdata[8*41 +: 8]};

  // Every header byte up to the end of the UDP dst port must be present.
  assign hdr_valid = (tpid == 16'h8100) && (etype == 16'h0800) && (proto == 8'h11) &&
                     (&s_axis.tkeep[41:0]);

  logic data_room, ctrl_room, s_ready, accept;
  logic route_data, route_ctrl, route_drop;

  always_comb begin
    cls_d = CLS_DROP;
    if (hdr_valid) cls_d = (dport == CTRL_UDP_PORT) ? CLS_CTRL : CLS_DATA;
  end

  // A buffer can take a beat if it is empty or is being drained this cycle.
  assign data_room = !d_valid_q || m_data_axis.tready;
  assign ctrl_room = !c_valid_q || m_ctrl_axis.tready;

  // Ready only looks at the port the current beat is headed for, so a stalled
  // port never blocks a packet bound for the other one.
  always_comb begin
    s_ready = 1'b1;
    unique case (state_q)
      ST_FWD_DATA: s_ready = data_room;
      ST_FWD_CTRL: s_ready = ctrl_room;
      ST_DROP:     s_ready = 1'b1;
      default: begin
        if (s_axis.tvalid) begin
          if (cls_d == CLS_DATA)      s_ready = data_room;
          else if (cls_d == CLS_CTRL) s_ready = ctrl_room;
        end
      end
    endcase
  end

  assign accept     = s_axis.tvalid && s_ready;
  assign route_data = accept && ((state_q == ST_FWD_DATA) ||
                                 (state_q == ST_IDLE && cls_d == CLS_DATA));
  assign route_ctrl = accept && ((state_q == ST_FWD_CTRL) ||
                                 (state_q == ST_IDLE && cls_d == CLS_CTRL));
  assign route_drop = accept && ((state_q == ST_DROP) ||
                                 (state_q == ST_IDLE && cls_d == CLS_DROP));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      d_valid_q  <= 1'b0;
      d_last_q   <= 1'b0;
      d_data_q   <= '0;
      d_keep_q   <= '0;
      d_user_q   <= '0;
      c_valid_q  <= 1'b0;
      c_last_q   <= 1'b0;
      c_data_q   <= '0;
      c_keep_q   <= '0;
      c_user_q   <= '0;
      data_cnt_q <= '0;
      ctrl_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Single-beat packets never leave IDLE.
          if (accept && !s_axis.tlast) begin
            unique case (cls_d)
              CLS_DATA: state_q <= ST_FWD_DATA;
              CLS_CTRL: state_q <= ST_FWD_CTRL;
              default:  state_q <= ST_DROP;
            endcase
          end
        end
        default: if (accept && s_axis.tlast) state_q <= ST_IDLE;
      endcase

      // Load has priority over drain: routing only happens when there is room.
      if (route_data) begin
        d_valid_q <= 1'b1;
        d_last_q  <= s_axis.tlast;
        d_data_q  <= s_axis.tdata;
        d_keep_q  <= s_axis.tkeep;
        d_user_q  <= s_axis.tuser;
      end else if (m_data_axis.tready) begin
        d_valid_q <= 1'b0;
      end

      if (route_ctrl) begin
        c_valid_q <= 1'b1;
        c_last_q  <= s_axis.tlast;
        c_data_q  <= s_axis.tdata;
        c_keep_q  <= s_axis.tkeep;
        c_user_q  <= s_axis.tuser;
      end else if (m_ctrl_axis.tready) begin
        c_valid_q <= 1'b0;
      end

      if (d_valid_q && m_data_axis.tready && d_last_q) data_cnt_q <= data_cnt_q + CNT_WIDTH'(1);
      if (c_valid_q && m_ctrl_axis.tready && c_last_q) ctrl_cnt_q <= ctrl_cnt_q + CNT_WIDTH'(1);
      if (route_drop && s_axis.tlast)                  drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign s_axis.tready      = s_ready;
  assign m_data_axis.tvalid = d_valid_q;
  assign m_data_axis.tlast  = d_last_q;
  assign m_data_axis.tdata  = d_data_q;
  assign m_data_axis.tkeep  = d_keep_q;
  assign m_data_axis.tuser  = d_user_q;
  assign m_ctrl_axis.tvalid = c_valid_q;
  assign m_ctrl_axis.tlast  = c_last_q;
  assign m_ctrl_axis.tdata  = c_data_q;
  assign m_ctrl_axis.tkeep  = c_keep_q;
  assign m_ctrl_axis.tuser  = c_user_q;
  assign data_pkt_cnt       = data_cnt_q;
  assign ctrl_pkt_cnt       = ctrl_cnt_q;
  assign drop_pkt_cnt       = drop_cnt_q;
endmodule
